// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset sequencer: opcodes,
// datapath mux selects, ALU operations, error codes and FSM state codes.
package mc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_SLTU = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;
  localparam logic [1:0] RES_IMM    = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_REGA  = 2'd2;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH     = 4'd0;
  localparam state_t S_DECODE    = 4'd1;
  localparam state_t S_MEM_ADR   = 4'd2;
  localparam state_t S_MEM_READ  = 4'd3;
  localparam state_t S_MEM_WB    = 4'd4;
  localparam state_t S_MEM_WRITE = 4'd5;
  localparam state_t S_EXEC_R    = 4'd6;
  localparam state_t S_EXEC_I    = 4'd7;
  localparam state_t S_ALU_WB    = 4'd8;
  localparam state_t S_BRANCH    = 4'd9;
  localparam state_t S_JAL       = 4'd10;
  localparam state_t S_JALR_ADR  = 4'd11;
  localparam state_t S_JALR_PC   = 4'd12;
  localparam state_t S_LUI       = 4'd13;
  localparam state_t S_ILLEGAL   = 4'd14;

  // States that hold a memory access open and therefore run the timeout counter.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decode for R-type and OP-IMM, plus the legality check on
// Func3/Func7 that DECODE uses to reject unsupported encodings.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic       is_rtype,
  input  logic [2:0] Func3,
  input  logic [6:0] Func7,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  always_comb begin
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    case (Func3)
      3'd0:    ALUControl = (is_rtype && Func7 == 7'h20) ? ALU_SUB : ALU_ADD;
      3'd2:    ALUControl = ALU_SLT;
      3'd3:    ALUControl = ALU_SLTU;
      3'd4:    ALUControl = ALU_XOR;
      3'd6:    ALUControl = ALU_OR;
      3'd7:    ALUControl = ALU_AND;
      default: illegal = 1'b1;
    endcase
    // OP-IMM carries immediate bits in Func7, so only R-type constrains it.
    if (is_rtype) begin
      if (Func7 == 7'h20) begin
        if (Func3 != 3'd0) illegal = 1'b1;
      end else if (Func7 != 7'h00) begin
        illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for a shared-memory RV32I-subset datapath with a
// mem_ready handshake, optional access timeout and sticky error code.
//
// state     | meaning
// FETCH     | read IR at PC, PC <= PC+4 on mem_ready
// DECODE    | dispatch on opcode, ALUOut <= OldPC + imm
// MEM_ADR   | ALUOut <= A + imm (load/store address)
// MEM_READ  | load access at ALUOut, wait for mem_ready
// MEM_WB    | rd <= Data
// MEM_WRITE | store access at ALUOut, wait for mem_ready
// EXEC_R    | ALUOut <= A op B
// EXEC_I    | ALUOut <= A op imm
// ALU_WB    | rd <= ALUOut
// BRANCH    | compare A-B, PC <= ALUOut when taken
// JAL       | PC <= ALUOut, ALUOut <= OldPC+4
// JALR_ADR  | ALUOut <= A + imm
// JALR_PC   | PC <= ALUOut, ALUOut <= OldPC+4
// LUI       | rd <= imm
// ILLEGAL   | terminal error state, left only by reset
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] OPCode,
  input  logic [2:0] Func3,
  input  logic [6:0] Func7,
  input  logic       Zero,
  input  logic       ALU_msb,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic       retire,
  output logic [1:0] error
);

  localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t        state_q, state_d, dispatch;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic          is_rtype, dec_illegal, waiting, expire, taken;
  logic [2:0]    dec_alu;

  assign is_rtype = (OPCode == OP_R_TYPE);

  mc_alu_decoder u_alu_dec (
    .is_rtype  (is_rtype),
    .Func3     (Func3),
    .Func7     (Func7),
    .ALUControl(dec_alu),
    .illegal   (dec_illegal)
  );

  always_comb begin
    dispatch = S_ILLEGAL;
    case (OPCode)
      OP_LW, OP_SW: dispatch = S_MEM_ADR;
      OP_R_TYPE:    dispatch = dec_illegal ? S_ILLEGAL : S_EXEC_R;
      OP_IMM:       dispatch = dec_illegal ? S_ILLEGAL : S_EXEC_I;
      OP_BRANCH:    dispatch = (Func3 == 3'd0 || Func3 == 3'd1 || Func3 == 3'd4 || Func3 == 3'd5)
                               ? S_BRANCH : S_ILLEGAL;
      OP_JAL:       dispatch = S_JAL;
      OP_JALR:      dispatch = S_JALR_ADR;
      OP_LUI:       dispatch = S_LUI;
      default:      dispatch = S_ILLEGAL;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (Func3)
      3'd0:    taken = Zero;
      3'd1:    taken = ~Zero;
      3'd4:    taken = ALU_msb;
      3'd5:    taken = ~ALU_msb;
      default: taken = 1'b0;
    endcase
  end

  // A ready in the expiry cycle completes the access, so expiry needs !mem_ready.
  assign waiting = is_mem_wait(state_q) && !mem_ready;
  assign expire  = (MEM_TIMEOUT != 0) && waiting && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = dispatch;
        if (dispatch == S_ILLEGAL) err_d = ERR_ILLEGAL;
      end
      S_MEM_ADR:   state_d = (OPCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_ALU_WB;
      S_JALR_ADR:  state_d = S_JALR_PC;
      S_JALR_PC:   state_d = S_ALU_WB;
      S_LUI:       state_d = S_FETCH;
      default:     state_d = S_ILLEGAL;
    endcase
    if (expire) begin
      state_d = S_ILLEGAL;
      err_d   = ERR_TIMEOUT;
    end
  end

  always_comb begin
    if (state_d != state_q)                 cnt_d = '0;
    else if (waiting && MEM_TIMEOUT != 0)   cnt_d = cnt_q + CW'(1);
    else                                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign error = err_q;

  // Gating on rst_n drops mem_req the moment reset asserts, mid-access included.
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REGB;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_I;
    ResultSrc  = RES_ALUOUT;
    retire     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          if (OPCode == OP_BRANCH)   ImmSrc = IMM_B;
          else if (OPCode == OP_JAL) ImmSrc = IMM_J;
          else                       ImmSrc = IMM_I;
        end
        S_MEM_ADR: begin
          ALUSrcA = SRCA_REGA;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = (OPCode == OP_SW) ? IMM_S : IMM_I;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEM_WB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
          retire    = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
          retire   = mem_ready;
        end
        S_EXEC_R: begin
          ALUSrcA    = SRCA_REGA;
          ALUControl = dec_alu;
        end
        S_EXEC_I: begin
          ALUSrcA    = SRCA_REGA;
          ALUSrcB    = SRCB_IMM;
          ALUControl = dec_alu;
        end
        S_ALU_WB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = SRCA_REGA;
          ALUControl = ALU_SUB;
          PCWrite    = taken;
          retire     = 1'b1;
        end
        S_JAL, S_JALR_PC: begin
          PCWrite = 1'b1;
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
        end
        S_JALR_ADR: begin
          ALUSrcA = SRCA_REGA;
          ALUSrcB = SRCB_IMM;
        end
        S_LUI: begin
          ImmSrc    = IMM_U;
          ResultSrc = RES_IMM;
          RegWrite  = 1'b1;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
